// File: rtl/alu_operand_fetch.sv
// Issue stage ahead of the ALU: decodes one instruction per handshake, reads the 8-entry register file with writeback bypass.
// One-cycle latency; a stalled bundle holds all outputs, and in_ready = !out_valid || out_ready.
module alu_operand_fetch #(
  parameter int WIDTH_DATA = 32,
  parameter int IMM_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic                  wb_en,
  input  logic [2:0]            wb_addr,
  input  logic [WIDTH_DATA-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH_DATA-1:0] operand_a,
  output logic [WIDTH_DATA-1:0] operand_b,
  output logic [4:0]            op_code,
  output logic [2:0]            rd_addr,
  output logic                  illegal_op,
  output logic [15:0]           illegal_count
);

  logic [WIDTH_DATA-1:0] rf [8];

  logic [4:0]       dec_op;
  logic [2:0]       dec_rd;
  logic [2:0]       dec_rs1;
  logic [2:0]       dec_rs2;
  logic             dec_imm_sel;
  logic [IMM_W-1:0] dec_imm;
  logic             reserved_unused;

  assign dec_op          = instr[31:27];
  assign dec_rd          = instr[26:24];
  assign dec_rs1         = instr[23:21];
  assign dec_rs2         = instr[20:18];
  assign dec_imm_sel     = instr[17];
  assign reserved_unused = instr[16];
  assign dec_imm         = instr[IMM_W-1:0];

  logic                  accept;
  logic                  legal;
  logic [WIDTH_DATA-1:0] rs1_val;
  logic [WIDTH_DATA-1:0] rs2_val;
  logic [WIDTH_DATA-1:0] imm_ext;
  logic [WIDTH_DATA-1:0] opb_sel;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign legal    = (dec_op >= 5'd4) && (dec_op <= 5'd13);
  assign imm_ext  = {{(WIDTH_DATA-IMM_W){dec_imm[IMM_W-1]}}, dec_imm};

  // Same-cycle writeback wins over the array so the operand never sees a stale value.
  always_comb begin
    rs1_val = rf[dec_rs1];
    rs2_val = rf[dec_rs2];
    if (dec_rs1 == 3'd0)
      rs1_val = '0;
    else if (wb_en && (wb_addr == dec_rs1))
      rs1_val = wb_data;
    if (dec_rs2 == 3'd0)
      rs2_val = '0;
    else if (wb_en && (wb_addr == dec_rs2))
      rs2_val = wb_data;
    opb_sel = dec_imm_sel ? imm_ext : rs2_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++)
        rf[i] <= '0;
      out_valid     <= 1'b0;
      operand_a     <= '0;
      operand_b     <= '0;
      op_code       <= '0;
      rd_addr       <= '0;
      illegal_op    <= 1'b0;
      illegal_count <= '0;
    end else begin
      if (wb_en && (wb_addr != 3'd0))
        rf[wb_addr] <= wb_data;

      illegal_op <= accept && !legal;

      if (accept && legal) begin
        out_valid <= 1'b1;
        operand_a <= rs1_val;
        operand_b <= opb_sel;
        op_code   <= dec_op;
        rd_addr   <= dec_rd;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept && !legal && (illegal_count != 16'hFFFF))
        illegal_count <= illegal_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed bench for alu_operand_fetch with hand-computed expectations.
module tb_alu_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  op_code;
  logic [2:0]  rd_addr;
  logic        illegal_op;
  logic [15:0] illegal_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_operand_fetch #(.WIDTH_DATA(32), .IMM_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .operand_a(operand_a), .operand_b(operand_b),
    .op_code(op_code), .rd_addr(rd_addr),
    .illegal_op(illegal_op), .illegal_count(illegal_count)
  );

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic isel, input logic [15:0] imm);
    return {op, rd, rs1, rs2, isel, 1'b0, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; wb_en = 1'b0; wb_addr = '0;
    wb_data = '0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_operand_a", operand_a, 32'd0);
    check("rst_operand_b", operand_b, 32'd0);
    check("rst_op_code", 32'(op_code), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_illegal_op", 32'(illegal_op), 32'd0);
    check("rst_illegal_count", 32'(illegal_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Load R3 and R4
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 32'h0000_0010; step();
    wb_addr = 3'd4; wb_data = 32'h0000_0003; step();
    wb_en = 1'b0;

    in_valid = 1'b1; instr = mk(5'd4, 3'd5, 3'd3, 3'd4, 1'b0, 16'h0000); step();
    check("basic_out_valid", 32'(out_valid), 32'd1);
    check("basic_operand_a", operand_a, 32'h10);
    check("basic_operand_b", operand_b, 32'h3);
    check("basic_op_code", 32'(op_code), 32'd4);
    check("basic_rd_addr", 32'(rd_addr), 32'd5);

    instr = mk(5'd5, 3'd1, 3'd3, 3'd0, 1'b1, 16'hFFFE); step();
    check("imm_out_valid", 32'(out_valid), 32'd1);
    check("imm_operand_a", operand_a, 32'h10);
    check("imm_operand_b", operand_b, 32'hFFFF_FFFE);
    check("imm_op_code", 32'(op_code), 32'd5);

    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 32'hDEAD_BEEF;
    instr = mk(5'd6, 3'd2, 3'd2, 3'd0, 1'b1, 16'h0005); step();
    check("bypass_operand_a", operand_a, 32'hDEAD_BEEF);
    check("bypass_operand_b", operand_b, 32'h5);

    // A write to R0 must neither bypass nor land in the array
    wb_addr = 3'd0; wb_data = 32'h0000_1234;
    instr = mk(5'd7, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0000); step();
    wb_en = 1'b0;
    check("r0_bypass_a", operand_a, 32'd0);
    check("r0_bypass_b", operand_b, 32'd0);
    instr = mk(5'd7, 3'd1, 3'd0, 3'd2, 1'b0, 16'h0000); step();
    check("r0_read_a", operand_a, 32'd0);
    check("r2_array_b", operand_b, 32'hDEAD_BEEF);
    in_valid = 1'b0; step();
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // Backpressure
    out_ready = 1'b0; in_valid = 1'b1;
    instr = mk(5'd8, 3'd6, 3'd3, 3'd4, 1'b0, 16'h0000); step();
    check("bp_first_valid", 32'(out_valid), 32'd1);
    instr = mk(5'd9, 3'd7, 3'd4, 3'd3, 1'b0, 16'h0000);
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 32'h0000_0099;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      step();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_operand_a", operand_a, 32'h10);
      check("bp_operand_b", operand_b, 32'h3);
      check("bp_op_code", 32'(op_code), 32'd8);
      check("bp_rd_addr", 32'(rd_addr), 32'd6);
    end
    wb_en = 1'b0;
    out_ready = 1'b1; #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    step();
    check("b2b_out_valid", 32'(out_valid), 32'd1);
    check("b2b_op_code", 32'(op_code), 32'd9);
    check("b2b_operand_a", operand_a, 32'h3);
    check("b2b_operand_b", operand_b, 32'h99);
    check("b2b_rd_addr", 32'(rd_addr), 32'd7);

    // Illegal opcodes, including both edges of the legal range
    instr = mk(5'd0, 3'd1, 3'd1, 3'd1, 1'b0, 16'h0000); step();
    check("ill0_out_valid", 32'(out_valid), 32'd0);
    check("ill0_pulse", 32'(illegal_op), 32'd1);
    check("ill0_count", 32'(illegal_count), 32'd1);
    instr = mk(5'd31, 3'd1, 3'd1, 3'd1, 1'b0, 16'h0000); step();
    check("ill31_out_valid", 32'(out_valid), 32'd0);
    check("ill31_pulse", 32'(illegal_op), 32'd1);
    check("ill31_count", 32'(illegal_count), 32'd2);
    in_valid = 1'b0; step();
    check("ill_pulse_end", 32'(illegal_op), 32'd0);
    check("ill_count_hold", 32'(illegal_count), 32'd2);
    in_valid = 1'b1; instr = mk(5'd13, 3'd2, 3'd3, 3'd0, 1'b1, 16'h7FFF); step();
    check("op13_out_valid", 32'(out_valid), 32'd1);
    check("op13_op_code", 32'(op_code), 32'd13);
    check("op13_operand_b", operand_b, 32'h0000_7FFF);
    check("op13_no_pulse", 32'(illegal_op), 32'd0);
    instr = mk(5'd14, 3'd2, 3'd3, 3'd0, 1'b0, 16'h0000); step();
    check("op14_out_valid", 32'(out_valid), 32'd0);
    check("op14_count", 32'(illegal_count), 32'd3);
    instr = mk(5'd3, 3'd2, 3'd3, 3'd0, 1'b0, 16'h0000); step();
    check("op3_count", 32'(illegal_count), 32'd4);

    instr = mk(5'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000);
    for (int i = 0; i < 65540; i++)
      step();
    check("sat_count", 32'(illegal_count), 32'h0000_FFFF);
    check("sat_pulse", 32'(illegal_op), 32'd1);
    in_valid = 1'b0; step();

    // Reset while a bundle is stalled; the same-edge write is discarded
    out_ready = 1'b0; in_valid = 1'b1;
    instr = mk(5'd4, 3'd1, 3'd3, 3'd4, 1'b0, 16'h0000); step();
    check("stall_before_rst", 32'(out_valid), 32'd1);
    rst = 1'b1; wb_en = 1'b1; wb_addr = 3'd5; wb_data = 32'h0000_0055; step();
    rst = 1'b0; wb_en = 1'b0; in_valid = 1'b0;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_count", 32'(illegal_count), 32'd0);
    check("mrst_operand_a", operand_a, 32'd0);
    out_ready = 1'b1; in_valid = 1'b1;
    instr = mk(5'd4, 3'd1, 3'd3, 3'd5, 1'b0, 16'h0000); step();
    in_valid = 1'b0;
    check("mrst_r3_read", operand_a, 32'd0);
    check("mrst_r5_read", operand_b, 32'd0);
    check("mrst_new_valid", 32'(out_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_fetch.md
Name: alu_operand_fetch

Overview:
- Issue stage directly upstream of the ALU.
- Accepts one 32-bit instruction word per handshake and decodes it.
- Reads an 8-entry register file, with bypass from the writeback port.
- Presents registered operand_a, operand_b and op_code to the ALU, with a valid/ready handshake on both sides and illegal-opcode detection.

Parameters:
- WIDTH_DATA, 32, datapath and register width; must be >= 16.
- IMM_W, 16, immediate field width; sign-extended to WIDTH_DATA.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  instr is valid.
- in_ready  output  1  stage can accept instr this cycle.
- instr  input  32  instruction word.
- wb_en  input  1  register-file write enable.
- wb_addr  input  3  write address.
- wb_data  input  WIDTH_DATA  write data.
- out_valid  output  1  operand bundle is valid.
- out_ready  input  1  downstream accepts the bundle.
- operand_a  output  WIDTH_DATA  ALU operand A.
- operand_b  output  WIDTH_DATA  ALU operand B.
- op_code  output  5  ALU operation code.
- rd_addr  output  3  destination register carried to writeback.
- illegal_op  output  1  one-cycle pulse when an illegal instr is dropped.
- illegal_count  output  16  saturating count of dropped instrs.

Behaviour:
- Instruction encoding:
  - [31:27] op_code, [26:24] rd, [23:21] rs1, [20:18] rs2, [17] imm_sel.
  - [16] reserved, ignored.
  - [15:0] imm.
- Legal op_code values are 4..13. Any other value is illegal.
- Register file: 8 x WIDTH_DATA.
  - R0 always reads 0; writes to address 0 are ignored.
  - A write with wb_en=1 takes effect at the clock edge.
- Read with bypass: if wb_en=1, wb_addr==rsX and rsX!=0 in the accept cycle, the operand uses wb_data, not the stale array value.
- Operand selection:
  - operand_a = R[rs1].
  - operand_b = sign-extended imm when imm_sel=1, else R[rs2].
  - Sign extension replicates imm[15] into the upper WIDTH_DATA-16 bits.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - An instr is accepted when in_valid && in_ready.
  - Latency: a legal instr accepted in cycle N gives out_valid=1 with its bundle in cycle N+1.
  - While out_valid && !out_ready, all outputs hold stable. Writes into the register file during the stall do not alter the held operands.
  - A bundle is consumed when out_valid && out_ready. In that cycle a new instr may be accepted (back-to-back, full throughput).
  - If no new legal instr is accepted in the consume cycle, out_valid falls to 0 next cycle.
- Illegal instr when accepted:
  - It is not forwarded; out_valid behaves as if nothing was accepted.
  - illegal_op=1 for exactly the next cycle.
  - illegal_count increments, saturating at 16'hFFFF.
- Reset (rst=1 at a clock edge):
  - Outputs: out_valid=0; operand_a, operand_b, op_code, rd_addr = 0; illegal_op=0; illegal_count=0.
  - All registers R1..R7 = 0.
- Reset mid-operation: a held bundle is discarded; any in-flight write in the same cycle is also discarded.
- A concurrent writeback and accept on the same register always forwards; the array is updated at the same edge.

Test Plan:
- Reset, then wb R3=0x0000_0010, R4=0x0000_0003; accept instr op=4, rs1=3, rs2=4, imm_sel=0, rd=5 -> next cycle out_valid=1, operand_a=0x10, operand_b=0x3, op_code=4, rd_addr=5.
- Immediate path: op=5, rs1=3, imm_sel=1, imm=16'hFFFE -> operand_b=0xFFFF_FFFE.
- Same-cycle bypass: wb_en=1, wb_addr=2, wb_data=0xDEAD_BEEF while accepting rs1=2 -> operand_a=0xDEAD_BEEF. Writing address 0, then reading R0 -> 0.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable, even when wb writes rs1 meanwhile. Then out_ready=1 -> bundle consumed and the next instr accepted the same cycle, out_valid stays 1.
- Illegal: accept op_code=0, then op_code=31 -> no out_valid, illegal_op pulses twice, illegal_count=2. Force 65537 illegal instrs -> count holds 16'hFFFF.
- Assert rst while a bundle is stalled -> next cycle out_valid=0, illegal_count=0, and a read of R3 returns 0.
